// File: rtl/sweep_pkg.sv
// Shared types and constants for the bit sweep generator.
package sweep_pkg;

  // Top-level sequencing states.
  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

  // AUTO restarts the bit index each outer pass; STATIC keeps counting across passes.
  typedef enum logic {
    AUTO,
    STATIC
  } mode_t;

  localparam int unsigned OUTER_N = 3;
  localparam int unsigned INNER_N = 3;
  localparam int unsigned CNT_W   = 2;

  localparam logic [CNT_W-1:0] OUTER_LAST = CNT_W'(OUTER_N - 1);
  localparam logic [CNT_W-1:0] INNER_LAST = CNT_W'(INNER_N - 1);

endpackage

// File: rtl/sweep_index_ctr.sv
// Outer/inner beat counters and the registered bit index they imply.
module sweep_index_ctr
  import sweep_pkg::*;
#(
  parameter int unsigned WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     adv,
  input  mode_t                    mode,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     last
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam logic [IW-1:0] IDX_MAX = IW'(WIDTH - 1);

  logic [CNT_W-1:0] outer_q, outer_d;
  logic [CNT_W-1:0] inner_q, inner_d;
  logic [IW-1:0]    idx_q, idx_d;

  assign last = (outer_q == OUTER_LAST) && (inner_q == INNER_LAST);
  assign idx  = idx_q;

  // Next counter values; the final beat wraps everything back to zero.
  always_comb begin
    outer_d = outer_q;
    inner_d = inner_q;
    if (clr) begin
      outer_d = '0;
      inner_d = '0;
    end else if (adv) begin
      if (inner_q == INNER_LAST) begin
        inner_d = '0;
        outer_d = (outer_q == OUTER_LAST) ? '0 : outer_q + 1'b1;
      end else begin
        inner_d = inner_q + 1'b1;
      end
    end
  end

  // Next index; STATIC runs a separate position that wraps at WIDTH instead of multiplying.
  always_comb begin
    idx_d = idx_q;
    if (clr || (adv && last)) begin
      idx_d = '0;
    end else if (adv) begin
      if (mode == STATIC) begin
        idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      end else begin
        idx_d = IW'(inner_d);
      end
    end
  end

  // Counter and index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outer_q <= '0;
      inner_q <= '0;
      idx_q   <= '0;
    end else begin
      outer_q <= outer_d;
      inner_q <= inner_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/bit_sweep_gen.sv
// Walks a data word bit by bit in 3x3 beats with valid/ready handshake,
// then rotates the word left to form the next default word.
module bit_sweep_gen
  import sweep_pkg::*;
#(
  parameter int unsigned       WIDTH = 9,
  parameter logic [WIDTH-1:0]  INIT  = WIDTH'(9'b000000101)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     mode,
  input  logic [WIDTH-1:0]         seed,
  input  logic                     ready,
  output logic [WIDTH-1:0]         data,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     bit_out,
  output logic                     valid,
  output logic                     done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  mode_t            mode_q, mode_d;
  logic             ctr_clr;
  logic             ctr_adv;
  logic             ctr_last;

  sweep_index_ctr #(
    .WIDTH (WIDTH)
  ) u_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (ctr_clr),
    .adv  (ctr_adv),
    .mode (mode_q),
    .idx  (idx),
    .last (ctr_last)
  );

  // Sequencing: accept start only in IDLE, advance on handshake, rotate on leaving DONE.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mode_d  = mode_q;
    ctr_clr = 1'b0;
    ctr_adv = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          data_d  = seed;
          mode_d  = mode_t'(mode);
          ctr_clr = 1'b1;
          state_d = SWEEP;
        end
      end
      SWEEP: begin
        if (ready) begin
          ctr_adv = 1'b1;
          if (ctr_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        data_d  = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, data word and latched mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= INIT;
      mode_q  <= AUTO;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
    end
  end

  // Outputs decode straight from registers, so they hold steady through stalls.
  always_comb begin
    data    = data_q;
    valid   = (state_q == SWEEP);
    done    = (state_q == DONE);
    bit_out = data_q[idx];
  end

endmodule

// File: tb/tb_bit_sweep_gen.sv
// Directed bench for bit_sweep_gen: vector table plus handshake, reset and narrow-width sequences.
module tb_bit_sweep_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, mode, ready;
  logic [8:0] seed;
  logic [8:0] data;
  logic [3:0] idx;
  logic       bit_out, valid, done;

  logic       w4_start, w4_mode, w4_ready;
  logic [3:0] w4_seed, w4_data;
  logic [1:0] w4_idx;
  logic       w4_bit, w4_valid, w4_done;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  bit_sweep_gen #(
    .WIDTH (9),
    .INIT  (9'b000000101)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mode    (mode),
    .seed    (seed),
    .ready   (ready),
    .data    (data),
    .idx     (idx),
    .bit_out (bit_out),
    .valid   (valid),
    .done    (done)
  );

  bit_sweep_gen #(
    .WIDTH (4),
    .INIT  (4'b0101)
  ) dut4 (
    .clk     (clk),
    .rst     (rst),
    .start   (w4_start),
    .mode    (w4_mode),
    .seed    (w4_seed),
    .ready   (w4_ready),
    .data    (w4_data),
    .idx     (w4_idx),
    .bit_out (w4_bit),
    .valid   (w4_valid),
    .done    (w4_done)
  );

  typedef struct {
    logic       start;
    logic       mode;
    logic [8:0] seed;
    logic       ready;
    logic       valid;
    logic [3:0] idx;
    logic       bout;
    logic       done;
    logic [8:0] data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic md, logic [8:0] sd, logic rdy,
                              logic v, logic [3:0] ix, logic b, logic d, logic [8:0] dt);
    vec_t r;
    r.start = st; r.mode = md; r.seed = sd; r.ready = rdy;
    r.valid = v; r.idx = ix; r.bout = b; r.done = d; r.data = dt;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full 9-beat sweep on the 9-bit DUT; pat=1 stalls two of every three cycles.
  task automatic sweep9(input logic md, input logic [8:0] sd, input int pat);
    int  k;
    bit  acc;
    bit  seen_done;
    logic [3:0] e_idx;
    start = 1'b1; mode = md; seed = sd; ready = 1'b0;
    step();
    start = 1'b0; seed = '0;
    chk("first_beat_valid", 32'(valid), 32'd1);
    k = 0;
    seen_done = 1'b0;
    for (int c = 0; c < 100; c++) begin
      ready = (pat == 0) ? 1'b1 : ((c % 3) == 0);
      acc = valid && ready;
      step();
      if (acc) k++;
      if (done) begin
        seen_done = 1'b1;
        chk("beats_at_done", 32'(k), 32'd9);
        chk("valid_in_done", 32'(valid), 32'd0);
        chk("data_in_done", 32'(data), 32'(sd));
        break;
      end
      if (valid) begin
        if (k >= 9) chk("extra_beat", 32'(k), 32'd8);
        e_idx = md ? 4'(k % 9) : 4'(k % 3);
        chk("sweep_idx", 32'(idx), 32'(e_idx));
        chk("sweep_bit", 32'(bit_out), 32'(sd[e_idx]));
        chk("sweep_data", 32'(data), 32'(sd));
      end else begin
        chk("valid_dropped_early", 32'(valid), 32'd1);
      end
    end
    chk("done_seen", 32'(seen_done), 32'd1);
    ready = 1'b0;
    step();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("rotated_data", 32'(data), 32'({sd[7:0], sd[8]}));
  endtask

  initial begin
    int  k;
    bit  seen_done;
    logic [1:0] e4;

    rst = 1'b1;
    start = 1'b0; mode = 1'b0; seed = '0; ready = 1'b0;
    w4_start = 1'b0; w4_mode = 1'b0; w4_seed = '0; w4_ready = 1'b0;
    #12;
    rst = 1'b0;

    // Reset values and idle hold
    chk("rst_data", 32'(data), 32'h005);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_idx", 32'(idx), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_data", 32'(data), 32'h005);
      chk("idle_valid", 32'(valid), 32'd0);
      chk("idle_idx", 32'(idx), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
    end

    // AUTO sweep of 0x007, start during DONE ignored, then STATIC sweep of 0x155
    vecs.push_back(mk(1, 0, 9'h007, 1, 1, 0, 1, 0, 9'h007));
    vecs.push_back(mk(0, 0, 9'h000, 1, 1, 1, 1, 0, 9'h007));
    vecs.push_back(mk(0, 0, 9'h000, 1, 1, 2, 1, 0, 9'h007));
    vecs.push_back(mk(0, 0, 9'h000, 1, 1, 0, 1, 0, 9'h007));
    vecs.push_back(mk(0, 0, 9'h000, 1, 1, 1, 1, 0, 9'h007));
    vecs.push_back(mk(0, 0, 9'h000, 1, 1, 2, 1, 0, 9'h007));
    vecs.push_back(mk(0, 0, 9'h000, 1, 1, 0, 1, 0, 9'h007));
    vecs.push_back(mk(0, 0, 9'h000, 1, 1, 1, 1, 0, 9'h007));
    vecs.push_back(mk(0, 0, 9'h000, 1, 1, 2, 1, 0, 9'h007));
    vecs.push_back(mk(0, 0, 9'h000, 1, 0, 0, 0, 1, 9'h007));
    vecs.push_back(mk(1, 1, 9'h155, 1, 0, 0, 0, 0, 9'h00E));
    vecs.push_back(mk(1, 1, 9'h155, 1, 1, 0, 1, 0, 9'h155));
    vecs.push_back(mk(0, 0, 9'h000, 1, 1, 1, 0, 0, 9'h155));
    vecs.push_back(mk(0, 0, 9'h000, 1, 1, 2, 1, 0, 9'h155));
    vecs.push_back(mk(0, 0, 9'h000, 1, 1, 3, 0, 0, 9'h155));
    vecs.push_back(mk(0, 0, 9'h000, 1, 1, 4, 1, 0, 9'h155));
    vecs.push_back(mk(0, 0, 9'h000, 1, 1, 5, 0, 0, 9'h155));
    vecs.push_back(mk(0, 0, 9'h000, 1, 1, 6, 1, 0, 9'h155));
    vecs.push_back(mk(0, 0, 9'h000, 1, 1, 7, 0, 0, 9'h155));
    vecs.push_back(mk(0, 0, 9'h000, 1, 1, 8, 1, 0, 9'h155));
    vecs.push_back(mk(0, 0, 9'h000, 1, 0, 0, 0, 1, 9'h155));
    vecs.push_back(mk(0, 0, 9'h000, 1, 0, 0, 0, 0, 9'h0AB));

    foreach (vecs[i]) begin
      start = vecs[i].start; mode = vecs[i].mode; seed = vecs[i].seed; ready = vecs[i].ready;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].valid));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].done));
      chk($sformatf("vec%0d_data", i), 32'(data), 32'(vecs[i].data));
      if (vecs[i].valid) begin
        chk($sformatf("vec%0d_idx", i), 32'(idx), 32'(vecs[i].idx));
        chk($sformatf("vec%0d_bit", i), 32'(bit_out), 32'(vecs[i].bout));
      end
    end
    start = 1'b0; ready = 1'b0; seed = '0;

    // STATIC sweep with ready stalling 1,0,0,1,...
    sweep9(1'b1, 9'h155, 1);

    // Reset in the middle of a sweep
    start = 1'b1; mode = 1'b0; seed = 9'h1FF; ready = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("pre_rst_valid", 32'(valid), 32'd1);
    chk("pre_rst_idx", 32'(idx), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(valid), 32'd0);
    chk("async_rst_data", 32'(data), 32'h005);
    chk("async_rst_done", 32'(done), 32'd0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("post_rst_valid", 32'(valid), 32'd0);
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_data", 32'(data), 32'h005);
    end
    ready = 1'b0;

    // Fresh AUTO sweep after reset
    sweep9(1'b0, 9'h0F3, 0);

    // Narrow word: STATIC index wraps modulo 4
    w4_start = 1'b1; w4_mode = 1'b1; w4_seed = 4'b1010; w4_ready = 1'b1;
    step();
    w4_start = 1'b0;
    chk("w4_first_valid", 32'(w4_valid), 32'd1);
    k = 0;
    seen_done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (w4_done) begin
        seen_done = 1'b1;
        chk("w4_beats", 32'(k), 32'd9);
        break;
      end
      if (w4_valid) begin
        e4 = 2'(k % 4);
        chk("w4_idx", 32'(w4_idx), 32'(e4));
        chk("w4_bit", 32'(w4_bit), 32'(e4[0]));
        k++;
      end
      step();
    end
    chk("w4_done_seen", 32'(seen_done), 32'd1);
    w4_ready = 1'b0;
    step();
    chk("w4_rotated", 32'(w4_data), 32'h5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
